regfile_writeback: RTL
======================

# regfile_writeback

Write-port initiator for the 32 x 64-bit register file. It accepts writeback requests from the execute/memory stages over a valid/ready handshake and buffers them in a small FIFO. It drains the FIFO onto the register file's write port (write_en / write_addr / write_data) at one write per cycle. It also zeroes every register after reset and on request, so the register file itself needs no reset path.

## Interface
- WORDSIZE, 64: data width of one register.
- SIZE, 32: number of registers swept by init/clear; must be 2^ADDR_W.
- ADDR_W, 5: register address width.
- FIFO_DEPTH, 4: request buffer entries; power of two, >= 2.
- ZERO_REG, 1: when 1, requests to address 0 are accepted and discarded (never written).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  request present.
- in_ready  out  1  FIFO can take a request; equals !full (combinational from state).
- in_addr  in  ADDR_W  destination register.
- in_data  in  WORDSIZE  value to write.
- clear_req  in  1  one-cycle pulse: zero all registers.
- busy  out  1  high while in INIT or CLEAR.
- pending  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- write_en  out  1  register file write enable (registered).
- write_addr  out  ADDR_W  register file write address (registered).
- write_data  out  WORDSIZE  register file write data (registered).

## Operation
- Handshake: a request transfers at a posedge where in_valid && in_ready. in_valid and its payload must be held until the transfer. in_ready does not depend on in_valid.
- FIFO is circular with wrap-around pointers. Push happens on transfer. It is never pushed when full, and there is no pass-through when full.
- States:
  - INIT: entered on reset. Sweeps cnt = 0..SIZE-1, one per cycle, issuing write_en=1, write_addr=cnt, write_data=0. Goes to RUN after cnt = SIZE-1.
  - RUN: on each edge where the FIFO is non-empty, pops the head into the output registers. write_en=1 unless ZERO_REG && addr==0, in which case write_en=0 and the entry is still popped. When the FIFO is empty, write_en=0 and addr/data hold their last values.
  - CLEAR: entered from RUN at the edge where clear_req=1. Performs the same sweep as INIT, then returns to RUN. Address 0 is included in the sweep.
- Requests are accepted during INIT and CLEAR; the FIFO fills but is not drained until RUN.
- clear_req is ignored in INIT and CLEAR.
- clear_req and a pop at the same RUN edge: the pop completes and its write is issued in the next cycle. CLEAR starts one cycle later. The popped write therefore lands before the sweep and is zeroed by it.
- Simultaneous push and pop: occupancy is unchanged.
- Occupancy tracking: pending increments on push only, decrements on pop only.

## Timing
- Reset values: write_en=0, write_addr=0, write_data=0, pending=0, in_ready=1, busy=1 (state INIT, cnt=0).
- Reset asserted mid-operation: the FIFO is emptied, any sweep is aborted, and INIT restarts from address 0 after release.
- After reset release:
  - The first INIT write is presented in the cycle following the first posedge.
  - The sweep occupies SIZE consecutive cycles with write_en high.
  - busy falls at the edge that enters RUN.
- Request latency: transfer at edge k, pop at edge k+1 (FIFO empty, in RUN), write_en high during cycle k+1..k+2, and the register file captures at edge k+2.
- Throughput: one write per cycle sustained. With in_valid held high and the FIFO in RUN, pending stays at 0 or 1 and in_ready stays high.
- CLEAR: SIZE cycles of zero writes, plus one transition edge in and one out.

## Test plan
- Reset and init: release reset, then check 32 consecutive cycles with write_en=1, write_addr 0..31, data 0. busy drops after the sweep, and the next cycle has write_en=0.
- Single write: in RUN, transfer addr=5, data=0xDEAD_BEEF_0123_4567 at edge k. Check write_en=1, write_addr=5 and the data during cycle k+1, and write_en=0 in the next cycle.
- Backpressure and wrap: during INIT push addrs 1..4. Check in_ready=0 and pending=4, and that a fifth valid is held off. After RUN, check writes emerge in order 1,2,3,4. Then push 6 more and check correct order across the pointer wrap.
- x0 discard: in RUN push addr=0 data=0xFF, then addr=3 data=0x11. Check the slot for addr 0 has write_en=0, then addr 3 is written the following cycle.
- Clear with queue: push 3 requests, pulse clear_req on the same edge as the first pop. Check:
  - the first write is issued;
  - 32 zero writes follow, during which clear_req is ignored;
  - the remaining 2 requests drain afterwards.
- Async reset mid-clear: assert reset at sweep address 17. Check the outputs go to reset values immediately and pending=0, and that INIT restarts at address 0.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-port initiator for the register file: buffers writeback requests in a
// small FIFO, drains one per cycle, and zero-sweeps every register after reset or on clear.
module regfile_writeback #(
    parameter int unsigned WORDSIZE   = 64,
    parameter int unsigned SIZE       = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_W-1:0]             in_addr,
    input  logic [WORDSIZE-1:0]           in_data,
    input  logic                          clear_req,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          write_en,
    output logic [ADDR_W-1:0]             write_addr,
    output logic [WORDSIZE-1:0]           write_data
);
    localparam int unsigned     PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_CLEAR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]     w_cnt_nxt;

    logic [ADDR_W-1:0]     r_fifo_addr [FIFO_DEPTH];
    logic [WORDSIZE-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W:0]        r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    logic                  r_write_en;
    logic [ADDR_W-1:0]     r_write_addr;
    logic [WORDSIZE-1:0]   r_write_data;
    logic                  w_wen_nxt;
    logic [ADDR_W-1:0]     w_waddr_nxt;
    logic [WORDSIZE-1:0]   w_wdata_nxt;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = in_valid && !w_full;

    assign in_ready   = !w_full;
    assign busy       = (r_state != ST_RUN);
    assign pending    = r_count;
    assign write_en   = r_write_en;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A clear seen in RUN still pops this cycle; the sweep starts on the next edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_wen_nxt   = 1'b0;
        w_waddr_nxt = r_write_addr;
        w_wdata_nxt = r_write_data;
        unique case (r_state)
            ST_INIT, ST_CLEAR: begin
                w_wen_nxt   = 1'b1;
                w_waddr_nxt = r_cnt;
                w_wdata_nxt = '0;
                w_cnt_nxt   = r_cnt + ADDR_W'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (!(ZERO_REG && (r_fifo_addr[r_rptr] == '0))) begin
                        w_wen_nxt   = 1'b1;
                        w_waddr_nxt = r_fifo_addr[r_rptr];
                        w_wdata_nxt = r_fifo_data[r_rptr];
                    end
                end
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else begin
            r_write_en   <= w_wen_nxt;
            r_write_addr <= w_waddr_nxt;
            r_write_data <= w_wdata_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= in_addr;
            r_fifo_data[r_wptr] <= in_data;
        end
    end

endmodule
